// File: rtl/ex_flag_cond_stage.sv
// EX->MEM stage: registers the ALU result, owns NZCV, evaluates ARM condition codes.
// Optional macro COND_STATS_EN adds a saturating failed-condition counter (squash_cnt).
module ex_flag_cond_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RADDR_W   = 4,
  parameter logic [3:0]  FLAGS_RST = 4'b0000,
  parameter int unsigned STAT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [3:0]         in_alu_flags,
  input  logic [3:0]         in_cond,
  input  logic               in_set_flags,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_write,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_mem_write,
  output logic               out_executed,
  output logic [3:0]         flags_q
`ifdef COND_STATS_EN
  ,
  output logic [STAT_W-1:0]  squash_cnt
`endif
);

  logic accept;
  logic cond_pass;
  logic n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ARM condition evaluation against the committed flags
  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'hA:    cond_pass = (n_f == v_f);
      4'hB:    cond_pass = (n_f != v_f);
      4'hC:    cond_pass = !z_f && (n_f == v_f);
      4'hD:    cond_pass = z_f || (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end

  // Output slot and flags; flush has priority over both accept and drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_write <= 1'b0;
      out_executed  <= 1'b0;
      flags_q       <= FLAGS_RST;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= in_result;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write && cond_pass;
      out_mem_write <= in_mem_write && cond_pass;
      out_executed  <= cond_pass;
      if (cond_pass && in_set_flags) begin
        flags_q <= in_alu_flags;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  // Saturating count of accepted instructions whose condition failed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_cnt <= '0;
    end else if (accept && !cond_pass && (squash_cnt != '1)) begin
      squash_cnt <= squash_cnt + STAT_W'(1);
    end
  end
`else
  // Keeps STAT_W referenced when the counter is compiled out
  logic [STAT_W-1:0] unused_stat;
  assign unused_stat = '0;
`endif

endmodule
